// File: rtl/boot_loader.sv
// boot_loader: copies the boot ROM image into main memory after reset.
// The CPU is held in reset for the whole copy, and the block drives the
// ROM and memory strobes itself. Once the last word is written, the
// block passes CPU memory requests straight through to main memory and
// releases the CPU. A reboot request in DONE restarts the copy.
module boot_loader #(
    parameter int ROM_WORDS = 8,     // words copied, 1..8
    parameter int MEM_AW    = 9,     // main memory address width
    parameter int BASE_ADDR = 0      // memory address of ROM word 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reboot,
    // boot ROM port
    output logic              rom_cs,
    output logic              rom_we,
    output logic [2:0]        rom_addr,
    input  logic [15:0]       rom_dout,
    // CPU memory request
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [MEM_AW-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    // main memory port
    output logic              mem_cs,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ready,
    // CPU control / status
    output logic              cpu_rst,
    output logic              boot_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,    // strobes quiet, word index cleared
        RD   = 3'd1,    // present ROM address
        CAP  = 3'd2,    // ROM data settled; capture it
        WR   = 3'd3,    // write captured word, wait for mem_ready
        DONE = 3'd4     // copy complete, CPU owns the memory port
    } state_t;

    // Index of the final word; copying stops after this one is accepted.
    localparam logic [2:0]        LAST_IDX = 3'(ROM_WORDS - 1);
    // Base address reduced to the memory width so that the per-word
    // address wraps modulo 2^MEM_AW.
    localparam logic [MEM_AW-1:0] BASE     = MEM_AW'(BASE_ADDR);

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg,   idx_next;
    logic [15:0] data_reg,  data_next;

    // The ROM is read-only from this block's point of view.
    assign rom_we = 1'b0;

    // State, word index and captured data; reset restarts the copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
            data_reg  <= 16'h0000;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        rom_cs     = 1'b0;
        rom_addr   = 3'd0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = 16'h0000;
        cpu_rst    = 1'b1;
        boot_done  = 1'b0;

        case (state_reg)
            IDLE: begin
                idx_next   = 3'd0;
                state_next = RD;
            end

            RD: begin
                rom_cs     = 1'b1;
                rom_addr   = idx_reg;
                state_next = CAP;
            end

            // Address has been stable for a full cycle, so the ROM
            // output latch has settled and can be captured.
            CAP: begin
                rom_cs     = 1'b1;
                rom_addr   = idx_reg;
                data_next  = rom_dout;
                state_next = WR;
            end

            // Outputs stay constant while the memory stalls, so the
            // write is presented exactly once from the memory's view.
            WR: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = BASE + MEM_AW'(idx_reg);
                mem_din  = data_reg;
                if (mem_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = RD;
                    end
                end
            end

            // Transparent pass-through; the CPU runs.
            DONE: begin
                boot_done = 1'b1;
                cpu_rst   = 1'b0;
                mem_cs    = cpu_cs;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_din   = cpu_din;
                if (reboot) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Testbench for boot_loader: two instances (base 0 and base 0x1FC) share
// control inputs; each has its own registered ROM model. Expected memory
// writes are queued when a copy is started and popped as writes appear.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, reboot, mem_ready, cpu_cs, cpu_we;
    logic [8:0]  cpu_addr;
    logic [15:0] cpu_din;

    logic        rom_cs0, rom_we0, mem_cs0, mem_we0, cpu_rst0, boot_done0;
    logic [2:0]  rom_addr0;
    logic [15:0] rom_dout0 = 16'h0000;
    logic [8:0]  mem_addr0;
    logic [15:0] mem_din0;

    logic        rom_cs1, rom_we1, mem_cs1, mem_we1, cpu_rst1, boot_done1;
    logic [2:0]  rom_addr1;
    logic [15:0] rom_dout1 = 16'h0000;
    logic [8:0]  mem_addr1;
    logic [15:0] mem_din1;

    boot_loader #(.ROM_WORDS(8), .MEM_AW(9), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .reboot(reboot),
        .rom_cs(rom_cs0), .rom_we(rom_we0), .rom_addr(rom_addr0), .rom_dout(rom_dout0),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .mem_cs(mem_cs0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_din(mem_din0),
        .mem_ready(mem_ready), .cpu_rst(cpu_rst0), .boot_done(boot_done0)
    );

    boot_loader #(.ROM_WORDS(8), .MEM_AW(9), .BASE_ADDR('h1FC)) dut1 (
        .clk(clk), .rst(rst), .reboot(reboot),
        .rom_cs(rom_cs1), .rom_we(rom_we1), .rom_addr(rom_addr1), .rom_dout(rom_dout1),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_din(mem_din1),
        .mem_ready(mem_ready), .cpu_rst(cpu_rst1), .boot_done(boot_done1)
    );

    logic [15:0] rom_img [8];

    // Registered ROM: data appears the cycle after the address.
    always @(posedge clk) begin
        if (rom_cs0) rom_dout0 <= rom_img[rom_addr0];
        if (rom_cs1) rom_dout1 <= rom_img[rom_addr1];
    end

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // Scoreboard side: boot writes accepted by memory (sampled mid-cycle).
    always @(negedge clk) begin
        wr_t w;
        if (!rst && mem_cs0 && mem_we0 && mem_ready && !boot_done0) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut0_extra_write: addr %0h data %0h, none expected", mem_addr0, mem_din0);
            end else begin
                w = q0.pop_front();
                chk("dut0_wr_addr", 32'(mem_addr0), 32'(w.addr));
                chk("dut0_wr_data", 32'(mem_din0), 32'(w.data));
            end
        end
        if (!rst && mem_cs1 && mem_we1 && mem_ready && !boot_done1) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1_extra_write: addr %0h data %0h, none expected", mem_addr1, mem_din1);
            end else begin
                w = q1.pop_front();
                chk("dut1_wr_addr", 32'(mem_addr1), 32'(w.addr));
                chk("dut1_wr_data", 32'(mem_din1), 32'(w.data));
            end
        end
        if (rom_we0 !== 1'b0 || rom_we1 !== 1'b0) begin
            n_tests++; n_fail++;
            $display("FAIL rom_we: got %b%b expected 00", rom_we0, rom_we1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        wr_t w;
        for (int i = 0; i < 8; i++) begin
            w.addr = 9'(i);
            w.data = rom_img[i];
            q0.push_back(w);
            w.addr = 9'(32'h1FC + i);
            q1.push_back(w);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_rom"},  {29'd0, rom_cs0, rom_addr0 != 3'd0, rom_cs1}, 32'd0);
        chk({nm, "_mem0"}, {rom_we0, mem_cs0, mem_we0, 4'd0, mem_addr0, mem_din0}, 32'd0);
        chk({nm, "_mem1"}, {rom_we1, mem_cs1, mem_we1, 4'd0, mem_addr1, mem_din1}, 32'd0);
        chk({nm, "_ctl"},  {28'd0, cpu_rst0, boot_done0, cpu_rst1, boot_done1}, 32'b1010);
    endtask

    // Ticks until boot_done rises (bounded) and checks the edge number.
    task automatic await_done(input int exp_tick, input int start_tick, input string nm);
        int t = start_tick;
        bit seen = 0;
        while (!seen && t < exp_tick + 20) begin
            tick();
            t++;
            if (boot_done0) seen = 1;
        end
        chk({nm, "_done_edge"}, seen ? 32'(t) : 32'hFFFF_FFFF, 32'(exp_tick));
        chk({nm, "_cpu_rst_low"}, {30'd0, cpu_rst0, cpu_rst1}, 32'd0);
        chk({nm, "_dut1_done"}, {31'd0, boot_done1}, 32'd1);
        chk({nm, "_q_empty"}, 32'(q0.size() + q1.size()), 32'd0);
    endtask

    typedef struct {
        logic        cs, we;
        logic [8:0]  addr;
        logic [15:0] din;
        logic        e_cs, e_we;
        logic [8:0]  e_addr;
        logic [15:0] e_din;
    } vec_t;

    vec_t vecs [4];

    initial begin
        // CPU requests in DONE and the memory-port values expected
        vecs[0] = '{1'b1, 1'b1, 9'h055, 16'hABCD, 1'b1, 1'b1, 9'h055, 16'hABCD};
        vecs[1] = '{1'b1, 1'b0, 9'h1FF, 16'h0000, 1'b1, 1'b0, 9'h1FF, 16'h0000};
        vecs[2] = '{1'b0, 1'b0, 9'h000, 16'hFFFF, 1'b0, 1'b0, 9'h000, 16'hFFFF};
        vecs[3] = '{1'b0, 1'b1, 9'h100, 16'h1234, 1'b0, 1'b1, 9'h100, 16'h1234};

        rom_img = '{16'hF200, 16'h4000, 16'hF800, 16'hF400,
                    16'hB008, 16'h4000, 16'h4000, 16'h0008};

        rst = 1'b1; reboot = 1'b0; mem_ready = 1'b1;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h055; cpu_din = 16'hABCD;
        tick(); tick();
        chk_reset("reset");

        // Plain copy with a CPU write request pending throughout.
        push_expected();
        rst = 1'b0;
        tick();
        chk("e0_rd_state", {29'd0, rom_cs0, mem_cs0, mem_cs1}, 32'b100);
        await_done(25, 1, "run1");

        for (int i = 0; i < 4; i++) begin
            cpu_cs = vecs[i].cs; cpu_we = vecs[i].we;
            cpu_addr = vecs[i].addr; cpu_din = vecs[i].din;
            #1;
            chk($sformatf("pass%0d_dut0", i), {5'd0, mem_cs0, mem_we0, mem_addr0, mem_din0},
                {5'd0, vecs[i].e_cs, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_din});
            chk($sformatf("pass%0d_dut1", i), {5'd0, mem_cs1, mem_we1, mem_addr1, mem_din1},
                {5'd0, vecs[i].e_cs, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_din});
            tick();
        end

        // Memory stall of 4 cycles during word 3's write.
        cpu_cs = 1'b0; cpu_we = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset("reset2");
        push_expected();
        rst = 1'b0;
        repeat (12) tick();
        chk("stall_entry", {6'd0, mem_cs0, mem_addr0, mem_din0}, {6'd0, 1'b1, 9'h003, 16'hF400});
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("stall%0d_dut0", k), {5'd0, mem_cs0, mem_we0, mem_addr0, mem_din0},
                {5'd0, 1'b1, 1'b1, 9'h003, 16'hF400});
            chk($sformatf("stall%0d_dut1", k), {6'd0, mem_cs1, mem_addr1, mem_din1},
                {6'd0, 1'b1, 9'h1FF, 16'hF400});
        end
        mem_ready = 1'b1;
        await_done(29, 16, "stall");

        // Reset pulse during word 5's capture restarts from word 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_expected();
        repeat (17) tick();
        chk("cap5_rom", {28'd0, rom_cs0, rom_addr0}, {28'd0, 1'b1, 3'd5});
        rst = 1'b1;
        tick();
        chk_reset("mid_reset");
        rst = 1'b0;
        chk("partial_q", 32'(q0.size() + q1.size()), 32'd6);
        q0.delete();
        q1.delete();
        push_expected();
        await_done(25, 0, "restart");

        // Reboot from DONE detaches the CPU at once; mid-copy reboot ignored.
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h055; cpu_din = 16'hABCD;
        reboot = 1'b1;
        tick();
        reboot = 1'b0;
        push_expected();
        chk("reboot_ctl", {28'd0, cpu_rst0, boot_done0, cpu_rst1, boot_done1}, 32'b1010);
        chk("reboot_detach", {28'd0, mem_cs0, mem_we0, mem_cs1, mem_we1}, 32'd0);
        repeat (10) tick();
        reboot = 1'b1;
        tick();
        reboot = 1'b0;
        await_done(25, 11, "reboot");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Boot sequencer that copies the boot ROM image into main memory after reset, then hands the memory port to the CPU. It sits between the 8×16 boot ROM, the main DFF memory and the CPU memory interface. It holds the CPU in reset while copying and drives ROM and memory chip-selects itself. After the copy completes it becomes a transparent pass-through for CPU memory traffic.

## Interface
Parameters:
- ROM_WORDS, 8: number of ROM words copied (legal range 1..8).
- MEM_AW, 9: main memory address width.
- BASE_ADDR, 0: memory address receiving ROM word 0.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; one clock, synchronous and active-high.
- reboot  in  1  one-cycle request to re-run the copy; honoured only in DONE.
- rom_cs  out  1  ROM chip select.
- rom_we  out  1  ROM write enable; constant 0.
- rom_addr  out  3  ROM word address.
- rom_dout  in  16  ROM read data.
- cpu_cs, cpu_we  in  1 each  CPU memory request.
- cpu_addr  in  MEM_AW  CPU memory address.
- cpu_din  in  16  CPU write data.
- mem_cs, mem_we  out  1 each  main memory request.
- mem_addr  out  MEM_AW  main memory address.
- mem_din  out  16  main memory write data.
- mem_ready  in  1  memory accepts the current write when 1 (stall when 0).
- cpu_rst  out  1  CPU reset, active-high.
- boot_done  out  1  copy complete.

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE. There is a 3-bit word index idx and a 16-bit data register data_q.
- IDLE: all memory/ROM strobes are 0 and idx=0. Next state is RD.
- RD: rom_cs=1, rom_addr=idx. Next state is CAP.
- CAP: rom_cs=1, rom_addr=idx. data_q <= rom_dout. Next state is WR.
- WR: rom_cs=0. mem_cs=1, mem_we=1, mem_addr=BASE_ADDR+idx (truncated to MEM_AW, wraps modulo 2^MEM_AW), mem_din=data_q.
  - If mem_ready=0: stay in WR with all outputs held.
  - If mem_ready=1 and idx==ROM_WORDS-1: go to DONE.
  - If mem_ready=1 otherwise: idx <= idx+1 and go to RD.
- DONE: boot_done=1, cpu_rst=0, rom_cs=0.
  - mem_cs/mem_we/mem_addr/mem_din follow cpu_cs/cpu_we/cpu_addr/cpu_din combinationally.
  - reboot=1 goes to IDLE.
- Outside DONE: cpu_rst=1 and all cpu_* inputs are ignored. reboot is ignored outside DONE.
- rom_we is tied 0 in all states. This block never writes the ROM.
- Output decode is combinational from state. data_q, idx and state are registered.

## Timing
- Reset values: state=IDLE, idx=0, data_q=0. This gives rom_cs=0, rom_we=0, rom_addr=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, cpu_rst=1, boot_done=0.
- E0 is the first rising edge that samples rst=0; it moves IDLE→RD.
- Each word takes 3 cycles (RD, CAP, WR) plus one extra cycle per cycle of mem_ready=0.
- With mem_ready tied 1 and ROM_WORDS=8, DONE is entered at E24. boot_done=1 and cpu_rst=0 from then on.
- ROM read data is sampled one cycle after rom_cs/rom_addr are presented. This covers the ROM output latch settling.
- rst=1 in any state returns to IDLE on that edge. Outputs revert to reset values and the copy restarts from word 0. A partial copy is not resumed.
- reboot in DONE: IDLE at the next edge, where cpu_rst=1 and the memory port is detached from the CPU that same cycle. The copy then runs again with identical timing.
- rst and reboot asserted on the same edge: rst wins.

## Test plan
- Reset release, mem_ready=1, ROM image F200,4000,F800,F400,B008,4000,4000,0008 → memory writes at addr 0..7 with those values in order, one write per 3 cycles. boot_done rises at E24 and cpu_rst falls at E24.
- BASE_ADDR=0x1FC, MEM_AW=9 → writes land at 0x1FC,0x1FD,0x1FE,0x1FF,0x000,0x001,0x002,0x003 (wrap).
- mem_ready=0 for 4 cycles during word 3's WR → mem_addr=3 and mem_din=F400 held stable. boot_done is delayed to E28 and there are no duplicate or skipped writes.
- rst pulsed for 1 cycle during word 5's CAP → outputs return to reset values and the copy restarts at word 0. boot_done is seen 25 edges after rst drops.
- In DONE: cpu_cs=1, cpu_we=1, cpu_addr=0x055, cpu_din=ABCD → the same values appear on the mem_* outputs in the same cycle. The same CPU request before DONE → mem_* shows only boot traffic.
- reboot pulse in DONE → cpu_rst=1 and boot_done=0 on the next edge, and the full copy repeats. A reboot pulse mid-copy → no effect.
